// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: button-driven mode controller for a down-counting timer.
// Debounces three buttons, sequences IDLE/RUN/SET_MIN/SET_HR/ALARM,
// generates the seconds prescale tick and the self-clearing alarm.
// Optional macro AUTO_REPEAT_EN: held inc repeats up0/up1 every REP_CYCLES.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   btn_mode/start/inc raw buttons (async, active-high)
//   cnt_zero          datapath reads 00:00
//   set[1:0]          00 run/hold, 01 set minutes, 10 set hours
//   up0, up1          one-cycle minute / hour increment pulses
//   switch            down-counter enable
//   sec_tick          one-cycle pulse every TICK_DIV cycles in RUN
//   alarm             high while in ALARM
//   state[2:0]        IDLE=0 RUN=1 SET_MIN=2 SET_HR=3 ALARM=4
module clock_mode_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int TICK_DIV   = 100,
    parameter int ALARM_SECS = 5,
    parameter int REP_CYCLES = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_start,
    input  logic       btn_inc,
    input  logic       cnt_zero,
    output logic [1:0] set,
    output logic       up0,
    output logic       up1,
    output logic       switch,
    output logic       sec_tick,
    output logic       alarm,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_SET_MIN = 3'd2;
    localparam logic [2:0] S_SET_HR  = 3'd3;
    localparam logic [2:0] S_ALARM   = 3'd4;

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int AW = $clog2(ALARM_SECS + 1);

    // bit 0 = mode, bit 1 = start, bit 2 = inc
    logic [2:0]    btn_raw;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    deb_lvl_q, deb_lvl_d, deb_prev_q;
    logic [DW-1:0] deb_cnt_q [3];
    logic [DW-1:0] deb_cnt_d [3];
    logic [2:0]    press;
    logic          ev_mode, ev_start, ev_inc;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] pre_q, pre_d;
    logic [AW-1:0] sec_q, sec_d;
    logic          tick;
    logic [1:0]    set_q, set_d;
    logic          up0_q, up0_d, up1_q, up1_d;
    logic          switch_q, switch_d;
    logic          sec_tick_q, sec_tick_d;
    logic          alarm_q, alarm_d;

    assign btn_raw = {btn_inc, btn_start, btn_mode};

    // The counter tracks consecutive samples that differ from the current
    // level; since the level is binary those samples all agree.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_lvl_d[i] = deb_lvl_q[i];
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_lvl_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1))
                    deb_lvl_d[i] = sync2_q[i];
                else
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
        end
    end

    assign press    = deb_lvl_q & ~deb_prev_q;
    assign ev_mode  = press[0];
    assign ev_start = press[1] & ~press[0];
    assign ev_inc   = press[2] & ~|press[1:0];

    assign tick = (pre_q == TW'(TICK_DIV - 1));

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REP_CYCLES + 1);
    logic [RW-1:0] rep_q, rep_d;
    logic          rep_fire;
`endif

    always_comb begin
        state_d = state_q;
        up0_d   = 1'b0;
        up1_d   = 1'b0;
        sec_d   = sec_q;
        case (state_q)
            S_IDLE: begin
                if (ev_mode)
                    state_d = S_SET_MIN;
                else if (ev_start)
                    state_d = cnt_zero ? S_ALARM : S_RUN;
            end
            S_SET_MIN: begin
                if (ev_mode)
                    state_d = S_SET_HR;
                else if (ev_inc)
                    up0_d = 1'b1;
            end
            S_SET_HR: begin
                if (ev_mode)
                    state_d = S_IDLE;
                else if (ev_inc)
                    up1_d = 1'b1;
            end
            S_RUN: begin
                if (cnt_zero)
                    state_d = S_ALARM;
                else if (ev_mode || ev_start)
                    state_d = S_IDLE;
            end
            S_ALARM: begin
                if (|press)
                    state_d = S_IDLE;
                else if (tick) begin
                    if (sec_q == AW'(ALARM_SECS - 1))
                        state_d = S_IDLE;
                    else
                        sec_d = sec_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q)
            sec_d = '0;

`ifdef AUTO_REPEAT_EN
        // Repeat interval restarts on the initial press and on any
        // state change, so the first repeat is REP_CYCLES after the press.
        rep_d    = '0;
        rep_fire = 1'b0;
        if ((state_q == S_SET_MIN || state_q == S_SET_HR) &&
            state_d == state_q && !ev_inc && deb_lvl_q[2]) begin
            if (rep_q == RW'(REP_CYCLES - 1))
                rep_fire = 1'b1;
            else
                rep_d = rep_q + 1'b1;
        end
        if (rep_fire && state_q == S_SET_MIN)
            up0_d = 1'b1;
        if (rep_fire && state_q == S_SET_HR)
            up1_d = 1'b1;
`endif
    end

    // Prescaler runs only in RUN/ALARM and restarts on each entry.
    always_comb begin
        if ((state_d != S_RUN && state_d != S_ALARM) || state_d != state_q)
            pre_d = '0;
        else if (tick)
            pre_d = '0;
        else
            pre_d = pre_q + 1'b1;
    end

    always_comb begin
        case (state_d)
            S_SET_MIN: set_d = 2'b01;
            S_SET_HR:  set_d = 2'b10;
            default:   set_d = 2'b00;
        endcase
        switch_d   = (state_d == S_RUN);
        alarm_d    = (state_d == S_ALARM);
        sec_tick_d = tick && state_q == S_RUN && state_d == S_RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_lvl_q  <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 3; i++)
                deb_cnt_q[i] <= '0;
            state_q    <= S_IDLE;
            pre_q      <= '0;
            sec_q      <= '0;
            set_q      <= 2'b00;
            up0_q      <= 1'b0;
            up1_q      <= 1'b0;
            switch_q   <= 1'b0;
            sec_tick_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_lvl_q  <= deb_lvl_d;
            deb_prev_q <= deb_lvl_q;
            for (int i = 0; i < 3; i++)
                deb_cnt_q[i] <= deb_cnt_d[i];
            state_q    <= state_d;
            pre_q      <= pre_d;
            sec_q      <= sec_d;
            set_q      <= set_d;
            up0_q      <= up0_d;
            up1_q      <= up1_d;
            switch_q   <= switch_d;
            sec_tick_q <= sec_tick_d;
            alarm_q    <= alarm_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rep_q <= '0;
        else
            rep_q <= rep_d;
    end
`endif

    assign set      = set_q;
    assign up0      = up0_q;
    assign up1      = up1_q;
    assign switch   = switch_q;
    assign sec_tick = sec_tick_q;
    assign alarm    = alarm_q;
    assign state    = state_q;

endmodule
